// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter and sequencer for the single ram_dpi port, with programmable access latency.
// Define MEM_ARB_RR_EN for a round-robin tie-break; otherwise the LSU always wins ties.
module mem_arbiter #(
    parameter  int unsigned LATENCY = 1,
    localparam int unsigned AW      = 32,
    localparam int unsigned DW      = 32,
    localparam int unsigned MW      = 8,
    localparam int unsigned CW      = 4
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          ifu_req_valid,
    output logic          ifu_req_ready,
    input  logic [AW-1:0] ifu_req_addr,
    output logic          ifu_resp_valid,
    input  logic          ifu_resp_ready,
    output logic [DW-1:0] ifu_resp_data,

    input  logic          lsu_req_valid,
    output logic          lsu_req_ready,
    input  logic [AW-1:0] lsu_req_addr,
    input  logic          lsu_req_wen,
    input  logic [DW-1:0] lsu_req_wdata,
    input  logic [MW-1:0] lsu_req_wmask,
    output logic          lsu_resp_valid,
    input  logic          lsu_resp_ready,
    output logic [DW-1:0] lsu_resp_rdata,

    output logic          mem_valid,
    output logic          mem_wen,
    output logic [AW-1:0] mem_raddr,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic [MW-1:0] mem_wmask,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          own_lsu;
    logic [AW-1:0] lat_addr;
    logic          lat_wen;
    logic [DW-1:0] lat_wdata;
    logic [MW-1:0] lat_wmask;
    logic [DW-1:0] resp_data;

    logic          grant_lsu;
    logic          grant_ifu;
    logic          take_ifu;
    logic          take_lsu;
    logic          in_access;
    logic          do_write;
    logic          resp_done;

    // Tie-break between simultaneous requests
`ifdef MEM_ARB_RR_EN
    logic          last_lsu;
    assign grant_lsu = lsu_req_valid && !(ifu_req_valid && last_lsu);
`else
    assign grant_lsu = lsu_req_valid;
`endif
    assign grant_ifu = ifu_req_valid && !grant_lsu;

    assign take_ifu      = (state == IDLE) && !reset && grant_ifu;
    assign take_lsu      = (state == IDLE) && !reset && grant_lsu;
    assign ifu_req_ready = take_ifu;
    assign lsu_req_ready = take_lsu;

    // Memory port is driven only during an ACCESS cycle not killed by reset
    assign in_access = (state == ACCESS) && !reset;
    assign do_write  = in_access && own_lsu && lat_wen;
    assign mem_valid = in_access;
    assign mem_wen   = do_write;
    assign mem_raddr = in_access ? lat_addr : '0;
    assign mem_waddr = in_access ? lat_addr : '0;
    assign mem_wdata = do_write ? lat_wdata : '0;
    assign mem_wmask = do_write ? lat_wmask : '0;

    assign ifu_resp_data  = resp_data;
    assign lsu_resp_rdata = resp_data;
    assign resp_done      = own_lsu ? lsu_resp_ready : ifu_resp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            own_lsu        <= 1'b0;
            lat_addr       <= '0;
            lat_wen        <= 1'b0;
            lat_wdata      <= '0;
            lat_wmask      <= '0;
            resp_data      <= '0;
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_lsu       <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (take_ifu || take_lsu) begin
                        own_lsu   <= take_lsu;
                        lat_addr  <= take_lsu ? lsu_req_addr : ifu_req_addr;
                        lat_wen   <= take_lsu && lsu_req_wen;
                        lat_wdata <= take_lsu ? lsu_req_wdata : '0;
                        lat_wmask <= take_lsu ? lsu_req_wmask : '0;
`ifdef MEM_ARB_RR_EN
                        last_lsu  <= take_lsu;
`endif
                        if (LATENCY <= 1) begin
                            state <= ACCESS;
                        end else begin
                            cnt   <= CW'(LATENCY - 1);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end
                    if (cnt <= CW'(1)) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    resp_data <= (own_lsu && lat_wen) ? '0 : mem_rdata;
                    if (own_lsu) begin
                        lsu_resp_valid <= 1'b1;
                    end else begin
                        ifu_resp_valid <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (resp_done) begin
                        ifu_resp_valid <= 1'b0;
                        lsu_resp_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter and sequencer between the instruction-fetch unit (IFU) and the load/store unit (LSU) and the single shared `ram_dpi` port. It accepts one request at a time over valid/ready handshakes and inserts a programmable access delay so the core can be exercised against non-zero memory latency. It drives exactly one `ram_dpi` access cycle per transaction and returns a registered response to the requester that was granted.

## Interface
- `LATENCY`, default 1: cycles from request acceptance to the memory access cycle; legal range 1..15.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `ifu_req_valid` in 1 / `ifu_req_ready` out 1 / `ifu_req_addr` in 32: IFU read request.
- `ifu_resp_valid` out 1 / `ifu_resp_ready` in 1 / `ifu_resp_data` out 32: IFU read response.
- `lsu_req_valid` in 1 / `lsu_req_ready` out 1 / `lsu_req_addr` in 32: LSU request and address.
- `lsu_req_wen` in 1 / `lsu_req_wdata` in 32 / `lsu_req_wmask` in 8: LSU write enable, data and mask.
- `lsu_resp_valid` out 1 / `lsu_resp_ready` in 1 / `lsu_resp_rdata` out 32: LSU response; rdata is 0 for writes.
- `mem_valid`, `mem_wen` out 1; `mem_raddr`, `mem_waddr`, `mem_wdata` out 32; `mem_wmask` out 8: connect to `ram_dpi`.
- `mem_rdata` in 32: `ram_dpi` read data, combinational on `mem_raddr`.

## Operation
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE: requests are accepted only here. Ready is high only for the granted requester, and only while its valid is high and `reset` is low. On the handshake:
  - latch the address, wen, wdata, wmask and grant owner;
  - if LATENCY == 1, go to ACCESS; otherwise load the counter with LATENCY-1 and go to WAIT.
- WAIT: decrement the counter each cycle. Go to ACCESS in the cycle after the counter reaches 1. The counter is 4 bits wide and never wraps below 0.
- ACCESS: lasts exactly one cycle, with `mem_valid` = 1.
  - `mem_raddr` = `mem_waddr` = the latched address.
  - `mem_wen` = latched wen, and only for an LSU grant. `mem_wdata` and `mem_wmask` come from the latch when writing; otherwise they are 0.
  - Capture `mem_rdata` into the response register on reads and 0 on writes, then go to RESP.
- RESP: hold the owner's resp_valid and data stable until its resp_ready is seen high, then go to IDLE. The other requester's resp_valid stays 0.
- Arbitration when both valids are high in IDLE: see Configuration. With only one valid, that requester is granted.
- Requesters must hold valid and all request fields stable until ready. The arbiter never reads the request fields after the handshake cycle.
- Outside ACCESS, all `mem_*` outputs are 0.

## Timing
- Handshake at edge T:
  - ACCESS occupies cycle T+LATENCY;
  - resp_valid is high from T+LATENCY+1;
  - with resp_ready tied high, the next request can be accepted at T+LATENCY+2.
- At most one transaction is in flight. Throughput is one transaction per LATENCY+2 cycles.
- Reset values: state IDLE, counter 0, all resp_valid 0, all response data 0, `mem_*` 0, all req_ready 0 while `reset` is high.
- Reset asserted mid-transaction aborts it with no response. `mem_valid` is gated by `!reset`, so a write whose ACCESS cycle coincides with `reset` is not committed. A write aborted in WAIT is never issued.
- A resp_ready asserted before resp_valid has no effect. There is no combinational path from any resp_ready to any req_ready.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin tie-break.
  - A `last_grant` register is updated on every handshake; the tie goes to the requester not in `last_grant`.
  - Reset value of `last_grant` is LSU, so the first tie goes to IFU.
- Undefined: fixed priority, LSU always wins ties. No `last_grant` register is built.

## Test plan
- Reset, then IFU reads 0x8000_0000 with memory word 0x0000_0413, LATENCY=1 → `ifu_req_ready` high at edge T; `mem_valid` high only at T+1 with `mem_raddr` 0x8000_0000; `ifu_resp_data` 0x0000_0413 valid from T+2.
- LSU writes 0xDEAD_BEEF, mask 0x0F, to 0x8000_0100, then reads it back, LATENCY=3 → `mem_wen` pulses one cycle at T+3; `lsu_resp_rdata` 0 for the write; the read returns 0xDEAD_BEEF; no `mem_valid` in WAIT cycles.
- IFU and LSU valid together for 4 consecutive transactions:
  - `MEM_ARB_RR_EN` defined → grant order IFU, LSU, IFU, LSU;
  - undefined → LSU wins every tie.
- IFU holds `ifu_resp_ready` low for 5 cycles → `ifu_resp_valid` and data are held stable; `lsu_req_ready` stays 0 throughout; the LSU is accepted the cycle after the response handshake.
- `reset` pulsed for 1 cycle during WAIT of an LSU write to 0x8000_0200 (LATENCY=4) → no `mem_valid`, memory unchanged, no resp_valid; the next request is serviced normally.
- `reset` coincides with the ACCESS cycle of a write → `mem_valid` 0 in that cycle; state is IDLE next cycle.
